// File: rtl/spike_raster_fifo_pkg.sv
// Shared definitions for the spike raster event stream.
// The host-side decoder uses the same tag values and frame counter width.
//   tag_e            2-bit word tag in bits [15:14]
//   WORD_W / FRAME_W event word width / frame counter width
//   make_spike_word  builds a spike event from a zero-extended neuron index
//   make_frame_word  builds a frame marker from the frame number
package spike_raster_fifo_pkg;

  localparam int WORD_W  = 16;
  localparam int FRAME_W = 14;

  typedef enum logic [1:0] {
    TAG_IDLE  = 2'b00,  // reserved: the all-zero word means "empty"
    TAG_SPIKE = 2'b01,
    TAG_FRAME = 2'b10
  } tag_e;

  function automatic logic [WORD_W-1:0] make_spike_word(input logic [FRAME_W-1:0] idx);
    return {TAG_SPIKE, idx};
  endfunction

  function automatic logic [WORD_W-1:0] make_frame_word(input logic [FRAME_W-1:0] frame_no);
    return {TAG_FRAME, frame_no};
  endfunction

endpackage

// File: rtl/spike_raster_fifo_fifo.sv
// First-word-fall-through synchronous FIFO on an inferred block RAM.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head word, all zeros while empty
//   full/empty : occupancy flags
//   count      : occupancy, AW+1 bits so that 2**AW is representable
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] head_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = count_reg[AW];
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    count_next  = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // RAM with registered read of the next head address. When the word being
  // written is the next head (FIFO drains to empty or is empty), the RAM
  // still holds stale data at that address, so the write data is forwarded.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr_reg] <= din;
    if (do_push && (wr_ptr_reg == rd_ptr_next)) head_reg <= din;
    else                                        head_reg <= mem[rd_ptr_next];
  end

  assign dout  = empty ? '0 : head_reg;
  assign count = count_reg;

endmodule

// File: rtl/spike_raster_fifo.sv
// Spike raster event encoder and buffer feeding the block-throttled pipe out.
// Spike strobes become tagged spike words, frame strobes become numbered frame
// markers; both are buffered in a FWFT FIFO with loss accounting.
//   clk, reset   : pipe-side clock, synchronous active-high reset
//   enable       : 0 stops new captures (pending flush and frame counting go on)
//   spike_valid  : one strobe per neuron slot write
//   spike        : spike flag for that slot
//   neuron_index : slot index (NN+1 bits)
//   frame_start  : strobe when the neuron counter wraps to 0
//   rd           : pop head word
//   dout         : head word, 16'h0000 when empty
//   block_ready  : count >= BLOCK_WORDS
//   count        : FIFO occupancy
//   overflow     : sticky, set when any event is lost
//   drop_cnt     : saturating count of lost events
module spike_raster_fifo
  import spike_raster_fifo_pkg::*;
#(
  parameter int NN          = 8,
  parameter int AW          = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              spike_valid,
  input  logic              spike,
  input  logic [NN:0]       neuron_index,
  input  logic              frame_start,
  input  logic              rd,
  output logic [WORD_W-1:0] dout,
  output logic              block_ready,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  logic [FRAME_W-1:0] frame_no_reg;
  logic               pending_valid_reg;
  logic [WORD_W-1:0]  pending_word_reg;
  logic               overflow_reg;
  logic [15:0]        drop_cnt_reg;

  logic               spike_ev;
  logic               marker_ev;
  logic [WORD_W-1:0]  spike_word;
  logic               push_req;
  logic [WORD_W-1:0]  push_word;
  logic               load_pending;
  logic               lost_marker;
  logic               lost_spike;
  logic               fifo_drop;
  logic [1:0]         lost_n;
  logic [16:0]        drop_sum;
  logic [15:0]        drop_cnt_next;
  logic               fifo_full;
  logic               fifo_empty;

  assign spike_ev   = enable & spike_valid & spike;
  assign marker_ev  = enable & frame_start;
  assign spike_word = make_spike_word(FRAME_W'(neuron_index));

  // One FIFO write per cycle: pending spike first, then a marker, then a spike.
  // A spike colliding with a marker is parked so the marker lands first.
  // Strobe spacing keeps new events away from a pending flush; if one slips
  // through anyway it is counted as lost rather than silently discarded.
  always_comb begin
    push_req     = 1'b0;
    push_word    = spike_word;
    load_pending = 1'b0;
    lost_marker  = 1'b0;
    lost_spike   = 1'b0;
    if (pending_valid_reg) begin
      push_req    = 1'b1;
      push_word   = pending_word_reg;
      lost_marker = marker_ev;
      lost_spike  = spike_ev;
    end else if (marker_ev) begin
      push_req     = 1'b1;
      push_word    = make_frame_word(frame_no_reg);
      load_pending = spike_ev;
    end else if (spike_ev) begin
      push_req  = 1'b1;
      push_word = spike_word;
    end
  end

  // Full implies non-empty, so rd alone tells whether a slot frees up.
  assign fifo_drop     = push_req & fifo_full & ~rd;
  assign lost_n        = {1'b0, fifo_drop} + {1'b0, lost_marker} + {1'b0, lost_spike};
  assign drop_sum      = {1'b0, drop_cnt_reg} + 17'(lost_n);
  assign drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_no_reg      <= '0;
      pending_valid_reg <= 1'b0;
      pending_word_reg  <= '0;
      overflow_reg      <= 1'b0;
      drop_cnt_reg      <= '0;
    end else begin
      // Frame numbering runs even when the marker is dropped or capture is
      // disabled, so the host sees gaps in the marker sequence.
      if (frame_start) frame_no_reg <= frame_no_reg + FRAME_W'(1);
      pending_valid_reg <= load_pending;
      if (load_pending) pending_word_reg <= spike_word;
      if (lost_n != 2'd0) begin
        overflow_reg <= 1'b1;
        drop_cnt_reg <= drop_cnt_next;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (push_word),
    .pop   (rd),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign block_ready = (count >= (AW+1)'(BLOCK_WORDS));
  assign overflow    = overflow_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_spike_raster_fifo.sv
// Directed bench for spike_raster_fifo with a scoreboard queue of expected
// FIFO words; each read compares the head word against the queue front.
module tb_spike_raster_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        spike_valid;
  logic        spike;
  logic [8:0]  neuron_index;
  logic        frame_start;
  logic        rd;
  logic [15:0] dout;
  logic        block_ready;
  logic [10:0] count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  spike_raster_fifo #(
    .NN          (8),
    .AW          (10),
    .BLOCK_WORDS (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .spike_valid  (spike_valid),
    .spike        (spike),
    .neuron_index (neuron_index),
    .frame_start  (frame_start),
    .rd           (rd),
    .dout         (dout),
    .block_ready  (block_ready),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_spike(input int idx);
    logic [15:0] w;
    w = 16'h4000 | 16'(idx & 'h1FF);
    return w;
  endfunction

  function automatic logic [15:0] exp_frame(input int fno);
    logic [15:0] w;
    w = 16'h8000 | 16'(fno & 'h3FFF);
    return w;
  endfunction

  task automatic clear_inputs();
    spike_valid  = 1'b0;
    spike        = 1'b0;
    frame_start  = 1'b0;
    rd           = 1'b0;
    neuron_index = '0;
  endtask

  // Compare head word with the scoreboard front, then pop it.
  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=scoreboard_entry", tag, dout);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(dout), 32'(e));
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic drive_spike(input int idx);
    spike_valid  = 1'b1;
    spike        = 1'b1;
    neuron_index = 9'(idx);
  endtask

  initial begin
    clear_inputs();
    reset  = 1'b1;
    enable = 1'b1;
    step();
    step();
    reset = 1'b0;
    $display("reset released");

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_block_ready", 32'(block_ready), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // 1: single spike then read
    drive_spike(5);
    exp_q.push_back(exp_spike(5));
    step();
    clear_inputs();
    check("t1_dout", 32'(dout), 32'h4005);
    check("t1_count", 32'(count), 32'd1);
    pop_check("t1_pop");
    check("t1_dout_empty", 32'(dout), 32'h0);
    check("t1_count_empty", 32'(count), 32'd0);
    $display("single spike: dout/count/read done");

    // 3: marker and spike in the same cycle
    frame_start = 1'b1;
    drive_spike(9'h1FF);
    exp_q.push_back(exp_frame(0));
    exp_q.push_back(exp_spike(9'h1FF));
    step();
    clear_inputs();
    check("t3_count_1", 32'(count), 32'd1);
    check("t3_dout_marker", 32'(dout), 32'h8000);
    step();
    check("t3_count_2", 32'(count), 32'd2);
    pop_check("t3_pop_marker");
    pop_check("t3_pop_spike");
    check("t3_count_end", 32'(count), 32'd0);
    $display("marker+spike collision: ordering done");

    // spike=0 and enable=0 push nothing
    spike_valid  = 1'b1;
    spike        = 1'b0;
    neuron_index = 9'd7;
    step();
    clear_inputs();
    check("nospike_count", 32'(count), 32'd0);
    enable = 1'b0;
    drive_spike(3);
    step();
    clear_inputs();
    enable = 1'b1;
    check("disabled_count", 32'(count), 32'd0);

    // 2: frame markers from reset numbering
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1;
      exp_q.push_back(exp_frame(i));
      step();
      frame_start = 1'b0;
      step();
    end
    check("t2_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) pop_check("t2_pop_marker");
    $display("three frame markers: done");

    // frame_no wrap: advance with capture disabled up to 3FFF
    enable      = 1'b0;
    frame_start = 1'b1;
    for (int i = 0; i < 16380; i++) step();
    frame_start = 1'b0;
    enable      = 1'b1;
    check("wrap_disabled_count", 32'(count), 32'd0);
    frame_start = 1'b1;
    exp_q.push_back(16'hBFFF);
    step();
    frame_start = 1'b0;
    step();
    frame_start = 1'b1;
    exp_q.push_back(16'h8000);
    step();
    frame_start = 1'b0;
    pop_check("wrap_3fff");
    pop_check("wrap_0000");
    $display("frame number wrap: done");

    // 5: rd held while empty
    rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("empty_rd_dout", 32'(dout), 32'h0);
      check("empty_rd_count", 32'(count), 32'd0);
    end
    rd = 1'b0;
    check("empty_rd_overflow", 32'(overflow), 32'd0);
    $display("read while empty: done");

    // 4 and block_ready: fill to 1024
    for (int i = 0; i < 1024; i++) begin
      drive_spike(i);
      exp_q.push_back(exp_spike(i));
      step();
      check("fill_count", 32'(count), 32'(exp_q.size()));
      if (exp_q.size() == 255) check("block_ready_255", 32'(block_ready), 32'd0);
      if (exp_q.size() == 256) check("block_ready_256", 32'(block_ready), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive_spike(9'h100 + i);
      step();
    end
    clear_inputs();
    check("full_count", 32'(count), 32'd1024);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_drop_cnt", 32'(drop_cnt), 32'd3);
    check("full_first_word", 32'(dout), 32'(exp_q[0]));
    $display("overflow: count/overflow/drop_cnt done");

    // rd + push while full
    begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check("full_rdpush_head", 32'(dout), 32'(e));
    end
    rd = 1'b1;
    drive_spike(9'h0AA);
    exp_q.push_back(exp_spike(9'h0AA));
    step();
    clear_inputs();
    check("full_rdpush_count", 32'(count), 32'd1024);
    check("full_rdpush_drop_cnt", 32'(drop_cnt), 32'd3);
    while (exp_q.size() > 0) pop_check("drain");
    check("drain_count", 32'(count), 32'd0);
    check("drain_dout", 32'(dout), 32'h0);
    $display("full read+push and drain: done");

    // 6: reset with count=37 and pending set
    for (int i = 0; i < 36; i++) begin
      drive_spike(i + 20);
      step();
    end
    frame_start = 1'b1;
    drive_spike(9'h33);
    step();
    clear_inputs();
    check("t6_count_37", 32'(count), 32'd37);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("t6_count", 32'(count), 32'd0);
    check("t6_dout", 32'(dout), 32'h0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
    step();
    check("t6_pending_cleared", 32'(count), 32'd0);
    frame_start = 1'b1;
    exp_q.push_back(exp_frame(0));
    step();
    frame_start = 1'b0;
    check("t6_frame_count", 32'(count), 32'd1);
    pop_check("t6_frame_no");
    $display("reset mid-operation: done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
